// File: rtl/i2s_pkg.sv
// Shared types and defaults for the I2S endpoint blocks.
package i2s_pkg;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } chan_t;

    localparam int unsigned I2S_SYNC_STAGES = 2;

endpackage

// File: rtl/i2s_sync_edge.sv
// Multi-stage synchroniser for one edge-detected line plus W auxiliary lines;
// rise/fall strobes are registered off the synchronised edge line.
module i2s_sync_edge
    import i2s_pkg::*;
#(
    parameter int unsigned W           = 1,
    parameter int unsigned SYNC_STAGES = I2S_SYNC_STAGES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_edge,
    input  logic [W-1:0] i_aux,
    output logic [W-1:0] o_aux_s,
    output logic         o_rise,
    output logic         o_fall
);

    logic [W:0] r_sync [SYNC_STAGES];
    logic       r_prev;
    logic       r_rise;
    logic       r_fall;
    logic       w_edge_s;

    assign w_edge_s = r_sync[SYNC_STAGES-1][0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                r_sync[i] <= '0;
            end
            r_prev <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync[0] <= {i_aux, i_edge};
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= w_edge_s;
            r_rise <= w_edge_s & ~r_prev;
            r_fall <= ~w_edge_s & r_prev;
        end
    end

    assign o_aux_s = r_sync[SYNC_STAGES-1][W:1];
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/i2s_target.sv
// I2S clock-follower endpoint: follows external sclk/lrclk, receives on sdi,
// transmits on sdo and exchanges parallel L/R words with the system side.
module i2s_target
    import i2s_pkg::*;
#(
    parameter int unsigned DW          = 24,
    parameter int unsigned SYNC_STAGES = I2S_SYNC_STAGES
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sclk,
    input  logic          lrclk,
    input  logic          sdi,
    output logic          sdo,
    input  logic [DW-1:0] tx_ldata,
    input  logic [DW-1:0] tx_rdata,
    output logic          tx_rd_en,
    input  logic          tx_rd_valid,
    output logic          tx_underrun,
    output logic [DW-1:0] rx_ldata,
    output logic [DW-1:0] rx_rdata,
    output logic          rx_valid
);

    localparam int unsigned    CW      = $clog2(DW + 1);
    localparam logic [CW-1:0] DW_CNT  = CW'(DW);
    localparam logic [CW-1:0] DW_LAST = CW'(DW - 1);

    logic [1:0]    w_aux_s;
    logic          w_lr_s;
    logic          w_sdi_s;
    logic          w_rise;
    logic          w_fall;
    logic          w_accept;
    logic          w_fresh;
    logic [DW-1:0] w_tx_l;
    logic [DW-1:0] w_tx_r;
    logic [DW-1:0] w_rx_next;

    logic          r_lr_prev;
    chan_t         r_chan;
    logic [CW-1:0] r_rx_cnt;
    logic [DW-2:0] r_rx_shift;
    logic [DW-1:0] r_rx_hold;
    logic          r_framed;
    logic          r_load_pending;
    logic          r_fresh;
    logic          r_req_out;
    logic [DW-1:0] r_tx_l;
    logic [DW-1:0] r_tx_r;
    logic [DW-1:0] r_tx_r_cur;
    logic [DW-1:0] r_tx_shift;
    logic [DW-1:0] r_rx_ldata;
    logic [DW-1:0] r_rx_rdata;
    logic          r_rx_valid;
    logic          r_tx_rd_en;
    logic          r_tx_underrun;

    i2s_sync_edge #(
        .W           (2),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_edge  (sclk),
        .i_aux   ({lrclk, sdi}),
        .o_aux_s (w_aux_s),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    // Data returned in the same clk as a left load still counts for that load.
    always_comb begin
        w_lr_s    = w_aux_s[1];
        w_sdi_s   = w_aux_s[0];
        w_accept  = tx_rd_valid & r_req_out;
        w_fresh   = r_fresh | w_accept;
        w_tx_l    = w_accept ? tx_ldata : r_tx_l;
        w_tx_r    = w_accept ? tx_rdata : r_tx_r;
        w_rx_next = {r_rx_shift, w_sdi_s};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lr_prev      <= 1'b0;
            r_chan         <= CH_LEFT;
            r_rx_cnt       <= '0;
            r_rx_shift     <= '0;
            r_rx_hold      <= '0;
            r_framed       <= 1'b0;
            r_load_pending <= 1'b0;
            r_fresh        <= 1'b0;
            r_req_out      <= 1'b0;
            r_tx_l         <= '0;
            r_tx_r         <= '0;
            r_tx_r_cur     <= '0;
            r_tx_shift     <= '0;
            r_rx_ldata     <= '0;
            r_rx_rdata     <= '0;
            r_rx_valid     <= 1'b0;
            r_tx_rd_en     <= 1'b0;
            r_tx_underrun  <= 1'b0;
        end else begin
            r_rx_valid    <= 1'b0;
            r_tx_rd_en    <= 1'b0;
            r_tx_underrun <= 1'b0;

            if (w_accept) begin
                r_tx_l    <= tx_ldata;
                r_tx_r    <= tx_rdata;
                r_fresh   <= 1'b1;
                r_req_out <= 1'b0;
            end

            if (w_rise) begin
                r_lr_prev <= w_lr_s;
                if (w_lr_s != r_lr_prev) begin
                    r_load_pending <= 1'b1;
                    r_rx_cnt       <= '0;
                    r_chan         <= w_lr_s ? CH_RIGHT : CH_LEFT;
                    if (!w_lr_s) begin
                        r_framed <= 1'b1;
                    end else if (r_framed) begin
                        r_tx_rd_en <= 1'b1;
                        r_fresh    <= 1'b0;
                        r_req_out  <= 1'b1;
                    end
                end else if (r_rx_cnt < DW_CNT) begin
                    r_rx_shift <= w_rx_next[DW-2:0];
                    r_rx_cnt   <= r_rx_cnt + CW'(1);
                    if (r_rx_cnt == DW_LAST) begin
                        if (r_chan == CH_LEFT) begin
                            r_rx_hold <= w_rx_next;
                        end else if (r_framed) begin
                            r_rx_ldata <= r_rx_hold;
                            r_rx_rdata <= w_rx_next;
                            r_rx_valid <= 1'b1;
                        end
                    end
                end
            end

            // Zeros shift in behind the LSB, so sdo idles low for the slot tail.
            if (w_fall) begin
                if (!r_framed) begin
                    r_tx_shift <= '0;
                end else if (r_load_pending) begin
                    r_load_pending <= 1'b0;
                    if (r_chan == CH_LEFT) begin
                        r_tx_shift    <= w_fresh ? w_tx_l : '0;
                        r_tx_r_cur    <= w_fresh ? w_tx_r : '0;
                        r_tx_underrun <= ~w_fresh;
                    end else begin
                        r_tx_shift <= r_tx_r_cur;
                    end
                end else begin
                    r_tx_shift <= r_tx_shift << 1;
                end
            end
        end
    end

    assign sdo         = r_tx_shift[DW-1];
    assign tx_rd_en    = r_tx_rd_en;
    assign tx_underrun = r_tx_underrun;
    assign rx_ldata    = r_rx_ldata;
    assign rx_rdata    = r_rx_rdata;
    assign rx_valid    = r_rx_valid;

endmodule

// File: tb/tb_i2s_target.sv
// Bench acting as the I2S controller: drives sclk/lrclk/sdi, captures sdo,
// answers tx requests, and scoreboards received frames.
module tb_i2s_target;

    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic          sclk;
    logic          lrclk;
    logic          sdi;
    logic          sdo;
    logic [DW-1:0] tx_ldata;
    logic [DW-1:0] tx_rdata;
    logic          tx_rd_en;
    logic          tx_rd_valid;
    logic          tx_underrun;
    logic [DW-1:0] rx_ldata;
    logic [DW-1:0] rx_rdata;
    logic          rx_valid;

    int n_cmp = 0;
    int n_err = 0;
    int n_req = 0;
    int n_und = 0;

    logic [2*DW-1:0] q_rx[$];
    logic [DW-1:0]   q_tx[$];
    logic [2*DW-1:0] q_resp[$];

    always #5 clk = ~clk;

    i2s_target #(
        .DW          (DW),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sclk        (sclk),
        .lrclk       (lrclk),
        .sdi         (sdi),
        .sdo         (sdo),
        .tx_ldata    (tx_ldata),
        .tx_rdata    (tx_rdata),
        .tx_rd_en    (tx_rd_en),
        .tx_rd_valid (tx_rd_valid),
        .tx_underrun (tx_underrun),
        .rx_ldata    (rx_ldata),
        .rx_rdata    (rx_rdata),
        .rx_valid    (rx_valid)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // One sclk period: low 4 clk, high 4 clk; sdo sampled at the end of the high phase.
    task automatic sclk_period(input logic lr, input logic d, output logic s);
        sclk  = 1'b0;
        lrclk = lr;
        sdi   = d;
        repeat (4) @(negedge clk);
        sclk = 1'b1;
        repeat (4) @(negedge clk);
        s = sdo;
    endtask

    task automatic drive_slot(input logic lr, input logic [DW-1:0] w, input int len,
                              input int first, input bit chk);
        logic [DW-1:0] got;
        logic [DW-1:0] exp_w;
        logic          tail;
        logic          s;
        logic          d;
        got  = '0;
        tail = 1'b0;
        for (int k = first; k < len; k++) begin
            d = (k >= 1 && k <= DW) ? w[DW-k] : 1'b1;
            sclk_period(lr, d, s);
            if (k >= 1 && k <= DW) got = {got[DW-2:0], s};
            else tail = tail | s;
        end
        if (chk) begin
            if (q_tx.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL tx_queue: got empty expected entry at %0t", $time);
            end else begin
                exp_w = q_tx.pop_front();
                check(lr ? "tx_right_word" : "tx_left_word", 32'(got), 32'(exp_w));
                if (len > DW) check("tx_tail_zero", 32'(tail), 32'd0);
            end
        end
    endtask

    task automatic drive_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input int len);
        drive_slot(1'b0, l, len, 0, 1'b1);
        drive_slot(1'b1, r, len, 0, 1'b1);
    endtask

    task automatic check_outputs_zero();
        check("sdo_zero", 32'(sdo), 32'd0);
        check("rx_ldata_zero", 32'(rx_ldata), 32'd0);
        check("rx_rdata_zero", 32'(rx_rdata), 32'd0);
        check("rx_valid_zero", 32'(rx_valid), 32'd0);
        check("tx_rd_en_zero", 32'(tx_rd_en), 32'd0);
        check("tx_underrun_zero", 32'(tx_underrun), 32'd0);
    endtask

    // Monitor: pops expected frames on rx_valid, counts request/underrun pulses.
    initial begin
        logic [2*DW-1:0] e;
        forever begin
            @(negedge clk);
            if (rx_valid) begin
                if (q_rx.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL rx_unexpected: got %h/%h expected none at %0t",
                             rx_ldata, rx_rdata, $time);
                end else begin
                    e = q_rx.pop_front();
                    check("rx_ldata", 32'(rx_ldata), 32'(e[2*DW-1:DW]));
                    check("rx_rdata", 32'(rx_rdata), 32'(e[DW-1:0]));
                end
            end
            if (tx_rd_en) n_req++;
            if (tx_underrun) n_und++;
        end
    end

    // Responder: one stray valid with no request outstanding, then answers
    // requests from q_resp 10 clk after tx_rd_en until the queue runs dry.
    initial begin
        logic [2*DW-1:0] p;
        tx_ldata    = '0;
        tx_rdata    = '0;
        tx_rd_valid = 1'b0;
        @(negedge clk);
        while (rst) @(negedge clk);
        @(negedge clk);
        tx_ldata    = 24'hDEADBE;
        tx_rdata    = 24'hBEEF01;
        tx_rd_valid = 1'b1;
        @(negedge clk);
        tx_rd_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_rd_en && q_resp.size() != 0) begin
                p = q_resp.pop_front();
                repeat (10) @(negedge clk);
                tx_ldata    = p[2*DW-1:DW];
                tx_rdata    = p[DW-1:0];
                tx_rd_valid = 1'b1;
                @(negedge clk);
                tx_rd_valid = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp + 1, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        sclk  = 1'b1;
        lrclk = 1'b0;
        sdi   = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero();
        rst = 1'b0;
        repeat (6) @(negedge clk);

        q_resp.push_back({24'hA5A5A5, 24'h5A5A5A});
        q_resp.push_back({24'h800000, 24'h7FFFFF});
        q_resp.push_back({24'h000001, 24'hFFFFFF});

        // sdo words expected per checked slot, in order.
        q_tx.push_back(24'h000000); q_tx.push_back(24'h000000);  // f0 not framed
        q_tx.push_back(24'h000000); q_tx.push_back(24'h000000);  // f1 underrun
        q_tx.push_back(24'hA5A5A5); q_tx.push_back(24'h5A5A5A);
        q_tx.push_back(24'h800000); q_tx.push_back(24'h7FFFFF);
        q_tx.push_back(24'h000001); q_tx.push_back(24'hFFFFFF);
        q_tx.push_back(24'h000000); q_tx.push_back(24'h000000);  // f5 underrun
        q_tx.push_back(24'h000000); q_tx.push_back(24'h000000);  // f6 underrun
        q_tx.push_back(24'h000000);                              // f7 left only
        q_tx.push_back(24'h000000); q_tx.push_back(24'h000000);  // f8 after reset

        drive_frame(24'h111111, 24'h222222, 32);
        q_rx.push_back({24'h123456, 24'hFEDCBA});
        drive_frame(24'h123456, 24'hFEDCBA, 32);
        q_rx.push_back({24'h800000, 24'h7FFFFF});
        drive_frame(24'h800000, 24'h7FFFFF, 32);
        q_rx.push_back({24'h000001, 24'hFFFFFF});
        drive_frame(24'h000001, 24'hFFFFFF, 25);
        q_rx.push_back({24'hA5A5A5, 24'h5A5A5A});
        drive_frame(24'hA5A5A5, 24'h5A5A5A, 32);
        q_rx.push_back({24'h0F0F0F, 24'hF0F0F0});
        drive_frame(24'h0F0F0F, 24'hF0F0F0, 32);
        q_rx.push_back({24'hC3C3C3, 24'h3C3C3C});
        drive_frame(24'hC3C3C3, 24'h3C3C3C, 32);

        drive_slot(1'b0, 24'h777777, 32, 0, 1'b1);
        drive_slot(1'b1, 24'h888888, 10, 0, 1'b0);
        check("rx_ldata_before_rst", 32'(rx_ldata), 32'h00C3C3C3);
        rst = 1'b1;
        @(negedge clk);
        check_outputs_zero();
        rst = 1'b0;
        drive_slot(1'b1, 24'h888888, 32, 10, 1'b0);

        q_rx.push_back({24'h13579B, 24'h2468AC});
        drive_frame(24'h13579B, 24'h2468AC, 32);
        repeat (20) @(negedge clk);

        check("rx_frames_left", 32'(q_rx.size()), 32'd0);
        check("tx_queue_left", 32'(q_tx.size()), 32'd0);
        check("tx_rd_en_count", 32'(n_req), 32'd8);
        check("tx_underrun_count", 32'(n_und), 32'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
